spi_tx_ctrl: RTL
================

SPI_TX_CTRL -- requirements
Module: spi_tx_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 9, giving the frame length in bits (one per PISO stage).
REQ-002 The block SHALL have parameter CLK_DIV, default 4, giving clk cycles per SCLK half-period (legal range 1..255).
REQ-003 The block SHALL have parameter CS_SETUP, default 2, giving clk cycles from cs_n falling to the first SCLK low phase (legal range 1..15).
REQ-004 The block SHALL have port clk, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: transfer request, sampled in IDLE only.
REQ-007 The block SHALL have port piso_load, output, 1 bit: one-cycle strobe that parallel-loads the external PISO.
REQ-008 The block SHALL have port piso_shift, output, 1 bit: one-cycle strobe that advances the PISO by one bit.
REQ-009 The block SHALL have port sclk, output, 1 bit: serial clock, idle low (SPI mode 0).
REQ-010 The block SHALL have port cs_n, output, 1 bit: chip select, active low.
REQ-011 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse at the end of a completed frame.

Function
REQ-013 All outputs SHALL be registered, and the FSM SHALL have states IDLE, LOAD, SETUP, SCK_LO, SCK_HI and DONE.
REQ-014 In IDLE, start=1 at an edge SHALL move the FSM to LOAD, with busy=1, cs_n=0 and piso_load=1 during LOAD (exactly one cycle).
REQ-015 LOAD SHALL go to SETUP, which lasts CS_SETUP cycles with cs_n=0 and sclk=0, then goes to SCK_LO.
REQ-016 SCK_LO SHALL last CLK_DIV cycles with sclk=0, then go to SCK_HI.
REQ-017 SCK_HI SHALL last CLK_DIV cycles with sclk=1, and on exit SHALL increment the bit counter (width ceil(log2(WIDTH+1))).
REQ-018 piso_shift SHALL be asserted during the last SCK_HI cycle of bits 1..WIDTH-1 only, never for bit WIDTH, so that data changes on the SCLK falling edge.
REQ-019 On leaving SCK_HI, the FSM SHALL go to SCK_LO if the count is below WIDTH, else to DONE.
REQ-020 DONE SHALL last one cycle with cs_n=1, sclk=0, busy=1 and done=1, then go to IDLE, clearing the bit and divider counters.
REQ-021 The busy duration SHALL be 2 + CS_SETUP + 2*WIDTH*CLK_DIV cycles (76 with defaults), with exactly WIDTH rising SCLK edges per frame.
REQ-022 start SHALL be ignored in every state other than IDLE, with no queuing, including start=1 during DONE.
REQ-023 For back-to-back transfers, start held high SHALL restart from IDLE, giving a minimum cs_n-high gap of 2 cycles (DONE + IDLE).
REQ-024 piso_load and piso_shift SHALL never be asserted in the same cycle.
REQ-025 The divider counter SHALL reload on every phase change and SHALL never wrap past CLK_DIV-1.

Reset
REQ-026 With reset=1 at an edge, the next cycle SHALL show state IDLE, cs_n=1, sclk=0, busy=0, done=0, piso_load=0, piso_shift=0, and all counters 0.
REQ-027 Reset SHALL take priority over start in the same cycle.
REQ-028 Reset mid-transfer SHALL abort with no done pulse and no further strobes; the next start SHALL begin a full new frame.

Verification
REQ-029 Bench SHALL cover reset: hold reset 3 cycles with start=1 -> busy=0, cs_n=1, sclk=0, no strobes.
REQ-030 Bench SHALL cover a single frame (defaults): start pulse -> piso_load once, 8 piso_shift pulses, 9 sclk rising edges, busy high 76 cycles, done once, cs_n high again.
REQ-031 Bench SHALL cover timing: sclk high and low phases each 4 cycles, first sclk rise 2+4 cycles after LOAD, piso_shift coincident with the last sclk-high cycle.
REQ-032 Bench SHALL cover a mid-frame start: start pulsed at cycle 30 of a frame -> frame unchanged, no second load.
REQ-033 Bench SHALL cover back-to-back transfers: start held high for 2 frames -> cs_n high exactly 2 cycles between frames, 2 done pulses.
REQ-034 Bench SHALL cover abort: reset asserted after the 4th sclk rise -> next cycle IDLE outputs, no done; a following start yields a full 9-bit frame.

Source files
------------

// File: rtl/spi_tx_ctrl.sv
// SPI mode-0 transmit sequencer: drives chip select, serial clock and the
// load/shift strobes of an external parallel-in/serial-out shift register.
module spi_tx_ctrl #(
    parameter int WIDTH    = 9,
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic piso_load,
    output logic piso_shift,
    output logic sclk,
    output logic cs_n,
    output logic busy,
    output logic done
);

    localparam int BIT_W = $clog2(WIDTH + 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(WIDTH - 1);
    localparam logic [BIT_W-1:0] BIT_ONE    = BIT_W'(1);
    localparam logic [7:0]       DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [7:0]       SETUP_LAST = 8'(CS_SETUP - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETUP,
        SCK_LO,
        SCK_HI,
        DONE
    } state_t;

    state_t           state, state_next;
    logic [7:0]       div_cnt, div_next;
    logic [BIT_W-1:0] bit_cnt, bit_next;
    logic             load_next, shift_next, sclk_next, cs_n_next, busy_next, done_next;

    // The divider counts cycles within the current phase and restarts at 0 on
    // every phase change; the bit counter counts completed SCLK high phases.
    always_comb begin
        state_next = state;
        div_next   = div_cnt;
        bit_next   = bit_cnt;
        case (state)
            IDLE: begin
                div_next = '0;
                bit_next = '0;
                if (start) state_next = LOAD;
            end
            LOAD: begin
                div_next   = '0;
                state_next = SETUP;
            end
            SETUP: begin
                if (div_cnt == SETUP_LAST) begin
                    div_next   = '0;
                    state_next = SCK_LO;
                end else begin
                    div_next = div_cnt + 8'd1;
                end
            end
            SCK_LO: begin
                if (div_cnt == DIV_LAST) begin
                    div_next   = '0;
                    state_next = SCK_HI;
                end else begin
                    div_next = div_cnt + 8'd1;
                end
            end
            SCK_HI: begin
                if (div_cnt == DIV_LAST) begin
                    div_next   = '0;
                    bit_next   = bit_cnt + BIT_ONE;
                    state_next = (bit_cnt == BIT_LAST) ? DONE : SCK_LO;
                end else begin
                    div_next = div_cnt + 8'd1;
                end
            end
            DONE: begin
                div_next   = '0;
                bit_next   = '0;
                state_next = IDLE;
            end
            default: begin
                div_next   = '0;
                bit_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so that, once registered, they
    // line up exactly with the state they describe. The final bit gets no
    // shift: the register already holds the last bit and is reloaded next frame.
    always_comb begin
        load_next  = (state_next == LOAD);
        sclk_next  = (state_next == SCK_HI);
        shift_next = (state_next == SCK_HI) && (div_next == DIV_LAST) && (bit_next != BIT_LAST);
        cs_n_next  = (state_next == IDLE) || (state_next == DONE);
        busy_next  = (state_next != IDLE);
        done_next  = (state_next == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            piso_load  <= 1'b0;
            piso_shift <= 1'b0;
            sclk       <= 1'b0;
            cs_n       <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            div_cnt    <= div_next;
            bit_cnt    <= bit_next;
            piso_load  <= load_next;
            piso_shift <= shift_next;
            sclk       <= sclk_next;
            cs_n       <= cs_n_next;
            busy       <= busy_next;
            done       <= done_next;
        end
    end

endmodule
